// File: rtl/bin8_bcd_scan_driver_if.sv
// Handshake and digit-bus bundle for the binary-to-BCD scan driver.
// The master side feeds values and watches the display bus.
// The slave side is the driver itself.
interface bin8_bcd_scan_driver_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic [3:0] digit_data;
    logic [2:0] digit_en;
    logic       busy;

    modport master (
        output in_valid,
        output in_value,
        input  in_ready,
        input  digit_data,
        input  digit_en,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_value,
        output in_ready,
        output digit_data,
        output digit_en,
        output busy
    );
endinterface

// File: rtl/bin8_bcd_scan_driver.sv
// 8-bit binary to 3-digit BCD converter (sequential double-dabble) feeding a
// multiplexed seven-segment digit bus with active-low enables.
// The displayed value only changes on commit.
// The scanner runs freely and independently of the conversion engine.
module bin8_bcd_scan_driver #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bin8_bcd_scan_driver_if.slave        bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] w);
        logic [19:0] a;
        a = w;
        for (int n = 0; n < 3; n++) begin
            if (a[8 + 4*n +: 4] >= 4'd5) begin
                a[8 + 4*n +: 4] = a[8 + 4*n +: 4] + 4'd3;
            end else begin
                a[8 + 4*n +: 4] = a[8 + 4*n +: 4];
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    state_t           state_q;
    logic [19:0]      work_q;
    logic [2:0]       iter_q;
    logic [11:0]      bcd_disp_q;
    logic [11:0]      bcd_disp_d;
    logic             in_ready_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [3:0]       digit_data_q;
    logic [2:0]       digit_en_q;
    logic [3:0]       digit_data_d;
    logic [2:0]       digit_en_d;
    logic [19:0]      work_step_s;
    logic             commit_s;
    logic             wrap_s;
    logic             blank_s;

    assign work_step_s = dd_step(work_q);
    assign commit_s    = (state_q == CONV) && (iter_q == 3'd7);

    // Next displayed value: only the final iteration's result is ever committed.
    always_comb begin
        bcd_disp_d = bcd_disp_q;
        if (commit_s) begin
            bcd_disp_d = work_step_s[19:8];
        end else begin
            bcd_disp_d = bcd_disp_q;
        end
    end

    // Conversion FSM: handshake capture, eight shift iterations, commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= 20'h00000;
            iter_q     <= 3'd0;
            bcd_disp_q <= 12'h000;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        work_q     <= {12'h000, bus.in_value};
                        iter_q     <= 3'd0;
                        state_q    <= CONV;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CONV: begin
                    work_q <= work_step_s;
                    iter_q <= iter_q + 3'd1;
                    if (commit_s) begin
                        bcd_disp_q <= bcd_disp_d;
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Scanner next state: refresh counter wrap advances the digit index 0->1->2->0.
    always_comb begin
        wrap_s = (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            if (idx_q == 2'd2) begin
                idx_d = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
    end

    // Digit selection and leading-zero blanking from next-state index and value,
    // so a commit coinciding with a slot change shows the new value at once.
    always_comb begin
        digit_data_d = 4'h0;
        digit_en_d   = 3'b111;
        blank_s      = 1'b0;
        case (idx_d)
            2'd0: begin
                digit_data_d = bcd_disp_d[3:0];
                digit_en_d   = 3'b110;
                blank_s      = 1'b0;
            end
            2'd1: begin
                digit_data_d = bcd_disp_d[7:4];
                digit_en_d   = 3'b101;
                blank_s      = BLANK_LEADING && (bcd_disp_d[11:8] == 4'h0)
                                             && (bcd_disp_d[7:4] == 4'h0);
            end
            2'd2: begin
                digit_data_d = bcd_disp_d[11:8];
                digit_en_d   = 3'b011;
                blank_s      = BLANK_LEADING && (bcd_disp_d[11:8] == 4'h0);
            end
            default: begin
                digit_data_d = 4'h0;
                digit_en_d   = 3'b111;
                blank_s      = 1'b1;
            end
        endcase
        if (blank_s) begin
            digit_data_d = 4'h0;
            digit_en_d   = 3'b111;
        end else begin
            digit_data_d = digit_data_d;
            digit_en_d   = digit_en_d;
        end
    end

    // Scanner state and registered digit bus; enable and data update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= 2'd0;
            digit_data_q <= 4'h0;
            digit_en_q   <= 3'b110;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            digit_data_q <= digit_data_d;
            digit_en_q   <= digit_en_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.digit_data = digit_data_q;
    assign bus.digit_en   = digit_en_q;

endmodule
